// File: rtl/mul_cell_arbiter.sv
// Two-port round-robin front end for a single pipelined multiply cell.
// Each port has its own response FIFO. Credits bound in-flight work so that no FIFO can overflow.

module mul_rsp_port #(
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grant,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        rsp_ready,
  output logic        credit_ok,
  output logic        rsp_valid,
  output logic [31:0] rsp_data
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [RSP_DEPTH-1:0][31:0] mem;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count, credit;
  logic                       pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !reset && (count != '0);
  assign rsp_data  = rsp_valid ? mem[rd_ptr] : '0;
  // credit covers ops still in the multiplier, so a grant always has a FIFO slot waiting
  assign credit_ok = credit < CW'(RSP_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      credit <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({grant, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end
endmodule

module mul_cell_arbiter #(
  parameter int MUL_LATENCY = 1,
  parameter int RSP_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_result
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]         req_valid, credit_ok, elig, grant, push;
  logic [NUM_PORTS-1:0]         rsp_ready, rsp_valid;
  logic [NUM_PORTS-1:0][31:0]   rsp_data;
  logic                         last_grant;
  logic [MUL_LATENCY:1]         vld_pipe;
  logic [MUL_LATENCY:1]         port_pipe;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign elig      = req_valid & credit_ok & {NUM_PORTS{!reset}};

  // Contention goes to the port that did not win last time
  assign grant[0] = elig[0] && (!elig[1] || last_grant);
  assign grant[1] = elig[1] && (!elig[0] || !last_grant);

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    mul_src1 = '0;
    mul_src2 = '0;
    if (grant[0]) begin
      mul_src1 = req0_a;
      mul_src2 = req0_b;
    end else if (grant[1]) begin
      mul_src1 = req1_a;
      mul_src2 = req1_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      vld_pipe   <= '0;
      port_pipe  <= '0;
    end else begin
      if (|grant) last_grant <= grant[1];
      vld_pipe[1]  <= |grant;
      port_pipe[1] <= grant[1];
      for (int i = 2; i <= MUL_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        port_pipe[i] <= port_pipe[i-1];
      end
    end
  end

  // mul_result is only meaningful when the last tag stage is valid
  assign push[0] = vld_pipe[MUL_LATENCY] && !port_pipe[MUL_LATENCY];
  assign push[1] = vld_pipe[MUL_LATENCY] &&  port_pipe[MUL_LATENCY];

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    mul_rsp_port #(.RSP_DEPTH(RSP_DEPTH)) u_port (
      .clk       (clk),
      .reset     (reset),
      .grant     (grant[n]),
      .push      (push[n]),
      .push_data (mul_result),
      .rsp_ready (rsp_ready[n]),
      .credit_ok (credit_ok[n]),
      .rsp_valid (rsp_valid[n]),
      .rsp_data  (rsp_data[n])
    );
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
endmodule

// File: doc/mul_cell_arbiter.md
MUL_CELL_ARBITER -- requirements
Module: mul_cell_arbiter

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 1, meaning cycles from operands driven on mul_src1/mul_src2 to the matching mul_result; legal range 1..4.
REQ-002 SHALL have parameter RSP_DEPTH, default 4, meaning response FIFO entries per port; legal range 2..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1, requester holds an operand pair.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1, operand pair accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 each, multiplicand and multiplier.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid, output, 1, a product is available.
REQ-009 SHALL have ports rsp0_ready / rsp1_ready, input, 1, requester consumes the product.
REQ-010 SHALL have ports rsp0_data / rsp1_data, output, 32 each, low 32 bits of the product.
REQ-011 SHALL have ports mul_src1 / mul_src2, output, 32 each, operands to the shared multiply cell.
REQ-012 SHALL have port mul_result, input, 32, multiply cell result.

Function
REQ-013 SHALL grant at most one request per cycle; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-014 SHALL treat port N as eligible when reqN_valid=1 and credit_N < RSP_DEPTH, where credit_N = in-flight ops for N plus entries in FIFO N.
REQ-015 SHALL arbitrate round-robin: if only one port is eligible it is granted; if both are, the port not granted most recently is granted; last_grant updates only on a grant.
REQ-016 SHALL drive reqN_ready combinationally as grant_N; ready may depend on valid; requesters SHALL hold operands stable until the transfer.
REQ-017 SHALL drive mul_src1/mul_src2 combinationally with the granted port's a/b in the grant cycle, and 0 in cycles without a grant.
REQ-018 SHALL carry a {valid, port} tag through a MUL_LATENCY-stage shift register; a grant in cycle T causes mul_result to be captured into FIFO[port] at the end of cycle T+MUL_LATENCY.
REQ-019 SHALL assert rspN_valid whenever FIFO N is non-empty, present the head on rspN_data, and pop when rspN_valid and rspN_ready are both high.
REQ-020 SHALL drive rspN_data = 0 while rspN_valid=0.
REQ-021 SHALL support push and pop on the same FIFO in the same cycle, including push to an empty FIFO, where data becomes visible the next cycle.
REQ-022 SHALL increment credit_N on a grant to N, decrement it on a pop from N, and leave it unchanged when both occur in the same cycle.
REQ-023 SHALL never overflow a FIFO; the credit rule alone guarantees this, with no drop path.
REQ-024 SHALL return responses per port in grant order; ports are independent, so a stalled rsp port does not block the other port.
REQ-025 SHALL give a minimum latency from request transfer in cycle T to rspN_valid of cycle T+MUL_LATENCY+1.
REQ-026 SHALL sustain one grant per cycle to a single port with rsp_ready held high when RSP_DEPTH >= MUL_LATENCY+2.
REQ-027 SHALL ignore mul_result in cycles whose output tag stage is invalid.

Reset
REQ-028 SHALL, while reset=1, force req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0, rspN_data=0 and mul_src1=mul_src2=0.
REQ-029 SHALL, on reset, clear all tag valids, both FIFOs and both credit counters, and set last_grant=1 so port 0 wins the first contention.
REQ-030 SHALL, on reset asserted mid-operation, discard in-flight products; no response for a pre-reset request appears after reset deasserts.

Verification
REQ-031 Single op: req0 a=0x0000_1234, b=0x0000_0010 transfers in cycle T with MUL_LATENCY=1 -> mul_src1=0x1234 in cycle T; rsp0_valid=1 and rsp0_data=0x0001_2340 in cycle T+2.
REQ-032 Contention: both valid every cycle with rsp_ready=1 -> grants alternate 0,1,0,1 starting with port 0 after reset; each port receives its products in order.
REQ-033 Back-pressure: rsp0_ready=0, req0_valid=1 continuously, RSP_DEPTH=4 -> exactly 4 grants to port 0, then req0_ready=0; port 1 continues to be granted; raising rsp0_ready for one cycle permits exactly one further port-0 grant.
REQ-034 Wrap: a=0xFFFF_FFFF, b=0x0000_0002 -> rsp_data=0xFFFF_FFFE (low 32 bits only).
REQ-035 Simultaneous push/pop: FIFO holds 1 entry, pop and pipeline push occur in the same cycle -> occupancy stays 1 and credit is correct; no data is lost or duplicated.
REQ-036 Mid-op reset: 2 ops in flight, reset pulsed 1 cycle -> no rsp_valid for those ops; the first post-reset request returns a correct product with latency per REQ-025.
